// File: rtl/mig_port_responder_if.sv
// MIG-style user port: command FIFO, write-data FIFO and read-data FIFO signals.
// The master side is the controller; the slave side is the memory responder.
interface mig_port_responder_if;
   logic        cmd_en;
   logic [2:0]  cmd_instr;
   logic [5:0]  cmd_bl;
   logic [27:0] cmd_word_addr;
   logic        cmd_empty;
   logic        cmd_full;

   logic        wr_en;
   logic [3:0]  wr_mask;
   logic [31:0] wr_data;
   logic        wr_full;
   logic        wr_empty;
   logic [6:0]  wr_count;
   logic        wr_underrun;
   logic        wr_error;

   logic        rd_en;
   logic [31:0] rd_data;
   logic        rd_full;
   logic        rd_empty;
   logic [6:0]  rd_count;
   logic        rd_overflow;
   logic        rd_error;

   modport master (
      output cmd_en, cmd_instr, cmd_bl, cmd_word_addr, wr_en, wr_mask, wr_data, rd_en,
      input  cmd_empty, cmd_full, wr_full, wr_empty, wr_count, wr_underrun, wr_error,
             rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error
   );

   modport slave (
      input  cmd_en, cmd_instr, cmd_bl, cmd_word_addr, wr_en, wr_mask, wr_data, rd_en,
      output cmd_empty, cmd_full, wr_full, wr_empty, wr_count, wr_underrun, wr_error,
             rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error
   );
endinterface

// File: rtl/mig_port_responder.sv
// Behavioural MIG user-port responder: queued read/write/refresh commands
// executed in order against an internal 32-bit word memory.
module mig_port_responder #(
   parameter int ADDR_WIDTH     = 10,
   parameter int CMD_DEPTH      = 4,
   parameter int READ_LATENCY   = 4,
   parameter int REFRESH_CYCLES = 8
) (
   input  logic                clk,
   input  logic                rst,
   mig_port_responder_if.slave port
);

   localparam int FIFO_DEPTH = 64;
   localparam int CMD_PTR_W  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
   localparam int CMD_CNT_W  = $clog2(CMD_DEPTH + 1);

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ_WAIT, S_READ, S_REFRESH} state_t;

   typedef struct packed {
      logic [2:0]            instr;
      logic [5:0]            bl;
      logic [ADDR_WIDTH-1:0] addr;
   } cmd_t;

   typedef struct packed {
      logic [3:0]  mask;
      logic [31:0] data;
   } wr_word_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr;
   logic [5:0]            beats_left;
   logic [7:0]            timer;

   cmd_t                  cmd_mem [CMD_DEPTH];
   logic [CMD_PTR_W-1:0]  cmd_wr_ptr, cmd_rd_ptr;
   logic [CMD_CNT_W-1:0]  cmd_count;
   cmd_t                  cmd_head;
   logic                  cmd_push, cmd_pop;

   wr_word_t              wr_mem [FIFO_DEPTH];
   logic [5:0]            wr_wr_ptr, wr_rd_ptr;
   logic [6:0]            wr_count;
   wr_word_t              wr_head;
   logic                  wr_push, wr_pop;

   logic [31:0]           rd_mem [FIFO_DEPTH];
   logic [5:0]            rd_wr_ptr, rd_rd_ptr;
   logic [6:0]            rd_count;
   logic                  rd_push, rd_pop, rd_drop, rd_overflow;

   logic [31:0]           mem [2**ADDR_WIDTH];
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^port.cmd_word_addr[27:ADDR_WIDTH];

   assign cmd_head = cmd_mem[cmd_rd_ptr];
   assign wr_head  = wr_mem[wr_rd_ptr];

   // Full/empty decisions use the registered counts, so a push into a full
   // FIFO is dropped even if a pop happens on the same edge.
   assign cmd_push = port.cmd_en && (cmd_count != CMD_CNT_W'(CMD_DEPTH));
   assign cmd_pop  = (state == S_IDLE) && (cmd_count != '0);
   assign wr_push  = port.wr_en && (wr_count != 7'(FIFO_DEPTH));
   assign wr_pop   = (state == S_WRITE) && (wr_count != '0);
   assign rd_push  = (state == S_READ) && (rd_count != 7'(FIFO_DEPTH));
   assign rd_drop  = (state == S_READ) && (rd_count == 7'(FIFO_DEPTH));
   assign rd_pop   = port.rd_en && (rd_count != '0);

   function automatic logic [CMD_PTR_W-1:0] cmd_ptr_next(input logic [CMD_PTR_W-1:0] p);
      return (p == CMD_PTR_W'(CMD_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cmd_wr_ptr  <= '0;
         cmd_rd_ptr  <= '0;
         cmd_count   <= '0;
         wr_wr_ptr   <= '0;
         wr_rd_ptr   <= '0;
         wr_count    <= '0;
         rd_wr_ptr   <= '0;
         rd_rd_ptr   <= '0;
         rd_count    <= '0;
         rd_overflow <= 1'b0;
      end else begin
         if (cmd_push) cmd_wr_ptr <= cmd_ptr_next(cmd_wr_ptr);
         if (cmd_pop)  cmd_rd_ptr <= cmd_ptr_next(cmd_rd_ptr);
         cmd_count <= cmd_count + CMD_CNT_W'(cmd_push) - CMD_CNT_W'(cmd_pop);

         if (wr_push) wr_wr_ptr <= wr_wr_ptr + 1'b1;
         if (wr_pop)  wr_rd_ptr <= wr_rd_ptr + 1'b1;
         wr_count <= wr_count + 7'(wr_push) - 7'(wr_pop);

         if (rd_push) rd_wr_ptr <= rd_wr_ptr + 1'b1;
         if (rd_pop)  rd_rd_ptr <= rd_rd_ptr + 1'b1;
         rd_count <= rd_count + 7'(rd_push) - 7'(rd_pop);

         if (rd_drop) rd_overflow <= 1'b1;
      end
   end

   // NOTE: storage arrays have no reset; pointers and counts alone define FIFO
   // contents, and the word memory must keep its data across a reset.
   always_ff @(posedge clk) begin
      if (cmd_push)
         cmd_mem[cmd_wr_ptr] <= cmd_t'{instr: port.cmd_instr, bl: port.cmd_bl,
                                       addr: port.cmd_word_addr[ADDR_WIDTH-1:0]};
      if (wr_push)
         wr_mem[wr_wr_ptr] <= wr_word_t'{mask: port.wr_mask, data: port.wr_data};
      if (rd_push)
         rd_mem[rd_wr_ptr] <= mem[addr];
      if (wr_pop)
         for (int b = 0; b < 4; b++)
            if (!wr_head.mask[b]) mem[addr][8*b +: 8] <= wr_head.data[8*b +: 8];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         addr       <= '0;
         beats_left <= '0;
         timer      <= '0;
      end else begin
         unique case (state)
            S_IDLE: if (cmd_pop) begin
               addr       <= cmd_head.addr;
               beats_left <= cmd_head.bl;
               case (cmd_head.instr)
                  3'b000, 3'b010: state <= S_WRITE;
                  3'b001, 3'b011: begin
                     if (READ_LATENCY > 1) begin
                        state <= S_READ_WAIT;
                        timer <= 8'(READ_LATENCY - 2);
                     end else begin
                        state <= S_READ;
                     end
                  end
                  3'b100: begin
                     state <= S_REFRESH;
                     timer <= 8'(REFRESH_CYCLES - 1);
                  end
                  default: state <= S_IDLE;
               endcase
            end
            S_WRITE: if (wr_pop) begin
               addr <= addr + 1'b1;
               if (beats_left == '0) state <= S_IDLE;
               else                  beats_left <= beats_left - 1'b1;
            end
            S_READ_WAIT: begin
               if (timer == '0) state <= S_READ;
               else             timer <= timer - 1'b1;
            end
            S_READ: begin
               addr <= addr + 1'b1;
               if (beats_left == '0) state <= S_IDLE;
               else                  beats_left <= beats_left - 1'b1;
            end
            S_REFRESH: begin
               if (timer == '0) state <= S_IDLE;
               else             timer <= timer - 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign port.cmd_empty   = (cmd_count == '0);
   assign port.cmd_full    = (cmd_count == CMD_CNT_W'(CMD_DEPTH));
   assign port.wr_empty    = (wr_count == '0);
   assign port.wr_full     = (wr_count == 7'(FIFO_DEPTH));
   assign port.wr_count    = wr_count;
   assign port.wr_underrun = (state == S_WRITE) && (wr_count == '0);
   assign port.wr_error    = 1'b0;
   assign port.rd_data     = rd_mem[rd_rd_ptr];
   assign port.rd_empty    = (rd_count == '0);
   assign port.rd_full     = (rd_count == 7'(FIFO_DEPTH));
   assign port.rd_count    = rd_count;
   assign port.rd_overflow = rd_overflow;
   assign port.rd_error    = 1'b0;

endmodule

// File: tb/tb_mig_port_responder.sv
// Bench for mig_port_responder: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mig_port_responder;

   localparam int AW   = 10;
   localparam int CD   = 4;
   localparam int RL   = 4;
   localparam int RC   = 8;
   localparam int MEMW = 1 << AW;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mig_port_responder_if bus();

   mig_port_responder #(
      .ADDR_WIDTH(AW), .CMD_DEPTH(CD), .READ_LATENCY(RL), .REFRESH_CYCLES(RC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .port(bus)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { int instr; int bl; int addr; } cmd_t;
   typedef struct { logic [31:0] d; logic [3:0] m; } wr_t;
   typedef struct { logic [31:0] d; logic [31:0] v; } rd_t;

   cmd_t cmdq[$];
   wr_t  wrq[$];
   rd_t  rdq[$];
   logic [31:0] mem_m [MEMW];
   logic [31:0] mem_v [MEMW] = '{default: '0};   // known-byte mask per word
   int  job_kind  = 0;                           // 0 none, 1 write, 2 read, 3 refresh
   int  job_addr  = 0;
   int  job_left  = 0;
   int  job_delay = 0;
   bit  ovf_m     = 0;

   initial forever begin
      int cp, wp, rp;
      cmd_t c;
      wr_t  w;
      rd_t  r;
      @(posedge clk or negedge rst);
      if (!rst) begin
         cmdq.delete(); wrq.delete(); rdq.delete();
         job_kind = 0;
         ovf_m    = 0;
      end else begin
         cp = cmdq.size(); wp = wrq.size(); rp = rdq.size();
         case (job_kind)
            0: if (cp > 0) begin
               c = cmdq.pop_front();
               job_addr = c.addr;
               job_left = c.bl + 1;
               if (c.instr == 0 || c.instr == 2) job_kind = 1;
               else if (c.instr == 1 || c.instr == 3) begin job_kind = 2; job_delay = RL - 1; end
               else if (c.instr == 4) begin job_kind = 3; job_delay = RC; end
            end
            1: if (wp > 0) begin
               w = wrq.pop_front();
               for (int b = 0; b < 4; b++)
                  if (!w.m[b]) begin
                     mem_m[job_addr][8*b +: 8] = w.d[8*b +: 8];
                     mem_v[job_addr][8*b +: 8] = 8'hFF;
                  end
               job_addr = (job_addr + 1) % MEMW;
               job_left--;
               if (job_left == 0) job_kind = 0;
            end
            2: if (job_delay > 0) job_delay--;
               else begin
                  if (rp < 64) begin
                     r.d = mem_m[job_addr]; r.v = mem_v[job_addr];
                     rdq.push_back(r);
                  end else ovf_m = 1;
                  job_addr = (job_addr + 1) % MEMW;
                  job_left--;
                  if (job_left == 0) job_kind = 0;
               end
            3: begin job_delay--; if (job_delay == 0) job_kind = 0; end
            default: job_kind = 0;
         endcase
         if (bus.cmd_en && cp < CD) begin
            c.instr = int'(bus.cmd_instr); c.bl = int'(bus.cmd_bl);
            c.addr  = int'(bus.cmd_word_addr) % MEMW;
            cmdq.push_back(c);
         end
         if (bus.wr_en && wp < 64) begin
            w.d = bus.wr_data; w.m = bus.wr_mask;
            wrq.push_back(w);
         end
         if (bus.rd_en && rp > 0) void'(rdq.pop_front());
      end
   end

   // Every-cycle comparison, away from the active edge.
   initial forever begin
      @(negedge clk);
      check("cmd_empty",   32'(bus.cmd_empty),   32'(cmdq.size() == 0));
      check("cmd_full",    32'(bus.cmd_full),    32'(cmdq.size() == CD));
      check("wr_count",    32'(bus.wr_count),    32'(wrq.size()));
      check("wr_empty",    32'(bus.wr_empty),    32'(wrq.size() == 0));
      check("wr_full",     32'(bus.wr_full),     32'(wrq.size() == 64));
      check("wr_underrun", 32'(bus.wr_underrun), 32'(job_kind == 1 && wrq.size() == 0));
      check("rd_count",    32'(bus.rd_count),    32'(rdq.size()));
      check("rd_empty",    32'(bus.rd_empty),    32'(rdq.size() == 0));
      check("rd_full",     32'(bus.rd_full),     32'(rdq.size() == 64));
      check("rd_overflow", 32'(bus.rd_overflow), 32'(ovf_m));
      check("errors",      32'({bus.wr_error, bus.rd_error}), 32'd0);
      if (rdq.size() > 0)
         check("rd_data", bus.rd_data & rdq[0].v, rdq[0].d & rdq[0].v);
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wr(input logic [31:0] d, input logic [3:0] m);
      bus.wr_en = 1'b1; bus.wr_data = d; bus.wr_mask = m;
      step();
      bus.wr_en = 1'b0;
   endtask

   task automatic push_cmd(input logic [2:0] instr, input int bl, input int a);
      bus.cmd_en = 1'b1; bus.cmd_instr = instr; bus.cmd_bl = 6'(bl); bus.cmd_word_addr = 28'(a);
      step();
      bus.cmd_en = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (!(job_kind == 0 && cmdq.size() == 0) && n < 2000) begin step(); n++; end
      if (n >= 2000) check({name, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic pop_rd(input string name, input logic [31:0] exp);
      int n = 0;
      while (bus.rd_empty && n < 500) begin step(); n++; end
      if (bus.rd_empty) check({name, "_timeout"}, 32'd1, 32'd0);
      else begin
         check(name, bus.rd_data, exp);
         bus.rd_en = 1'b1;
         step();
         bus.rd_en = 1'b0;
      end
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int n;
      bus.cmd_en = 1'b0; bus.cmd_instr = '0; bus.cmd_bl = '0; bus.cmd_word_addr = '0;
      bus.wr_en = 1'b0; bus.wr_mask = '0; bus.wr_data = '0; bus.rd_en = 1'b0;

      repeat (3) step();
      check("rst_cmd_empty", 32'(bus.cmd_empty), 32'd1);
      check("rst_wr_count",  32'(bus.wr_count),  32'd0);
      check("rst_rd_count",  32'(bus.rd_count),  32'd0);
      check("rst_overflow",  32'(bus.rd_overflow), 32'd0);
      check("rst_underrun",  32'(bus.wr_underrun), 32'd0);
      rst = 1'b1;
      repeat (3) step();

      // Burst write then read back, with first-push latency measured.
      for (int i = 1; i <= 4; i++) push_wr(32'h1111_1111 * i, 4'h0);
      push_cmd(3'b000, 3, 'h10);
      wait_idle("wr_burst");
      push_cmd(3'b001, 3, 'h10);
      n = 0;
      while (bus.rd_empty && n < 50) begin step(); n++; end
      check("rd_latency", 32'(n), 32'(RL + 1));  // one IDLE pop cycle + READ_LATENCY
      wait_idle("rd_burst");
      check("rd_count_4", 32'(bus.rd_count), 32'd4);
      for (int i = 1; i <= 4; i++) pop_rd("burst_word", 32'h1111_1111 * i);

      // Byte-masked overwrite.
      push_wr(32'hAABB_CCDD, 4'h0);
      push_cmd(3'b010, 0, 5);
      push_wr(32'h0000_0000, 4'b1010);
      push_cmd(3'b000, 0, 5);
      push_cmd(3'b011, 0, 5);
      wait_idle("mask");
      pop_rd("masked_word", 32'hAA00_CC00);

      // Write underrun: 3 of 8 words present.
      for (int i = 0; i < 3; i++) push_wr(32'hC0DE_0000 + i, 4'h0);
      push_cmd(3'b000, 7, 'h40);
      repeat (10) step();
      check("underrun_high", 32'(bus.wr_underrun), 32'd1);
      for (int i = 3; i < 8; i++) push_wr(32'hC0DE_0000 + i, 4'h0);
      wait_idle("underrun");
      check("underrun_low", 32'(bus.wr_underrun), 32'd0);
      push_cmd(3'b001, 7, 'h40);
      wait_idle("underrun_rd");
      for (int i = 0; i < 8; i++) pop_rd("underrun_word", 32'hC0DE_0000 + i);

      // Address wrap; upper address bits beyond ADDR_WIDTH are ignored.
      for (int i = 0; i < 4; i++) push_wr(32'hD000_0000 + i, 4'h0);
      push_cmd(3'b000, 3, 'h1003FE);
      push_cmd(3'b001, 3, 'h3FE);
      push_cmd(3'b001, 1, 'h000);
      wait_idle("wrap");
      for (int i = 0; i < 4; i++) pop_rd("wrap_word", 32'hD000_0000 + i);
      for (int i = 2; i < 4; i++) pop_rd("wrap_low_word", 32'hD000_0000 + i);

      // Command FIFO full while the engine stalls on a write burst.
      push_cmd(3'b000, 3, 'h80);
      repeat (2) step();
      for (int i = 0; i < 4; i++) push_cmd(3'b001, 0, 'h80);
      check("cmd_full_4", 32'(bus.cmd_full), 32'd1);
      push_cmd(3'b001, 0, 'h81);
      for (int i = 0; i < 4; i++) push_wr(32'hE0E0_0000 + i, 4'h0);
      wait_idle("cmd_full");
      repeat (2) step();
      check("fifth_dropped", 32'(bus.rd_count), 32'd4);
      for (int i = 0; i < 4; i++) pop_rd("cmd_full_word", 32'hE0E0_0000);

      // Read FIFO overflow.
      push_cmd(3'b001, 63, 0);
      push_cmd(3'b001, 63, 0);
      wait_idle("overflow");
      check("ovf_rd_count", 32'(bus.rd_count), 32'd64);
      check("ovf_rd_full",  32'(bus.rd_full),  32'd1);
      check("ovf_flag",     32'(bus.rd_overflow), 32'd1);
      bus.rd_en = 1'b1;
      repeat (64) step();
      bus.rd_en = 1'b0;
      check("ovf_sticky",   32'(bus.rd_overflow), 32'd1);
      check("ovf_drained",  32'(bus.rd_empty), 32'd1);

      // Randomized traffic with a reset in the middle.
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) rst = 1'b0;
         if (c == 1502) begin
            check("rst_mid_ovf",   32'(bus.rd_overflow), 32'd0);
            check("rst_mid_empty", 32'(bus.cmd_empty),   32'd1);
            check("rst_mid_rd",    32'(bus.rd_count),    32'd0);
         end
         if (c == 1503) rst = 1'b1;
         bus.cmd_en        = ($urandom_range(0, 7) == 0);
         bus.cmd_instr     = 3'($urandom_range(0, 7));
         bus.cmd_bl        = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(0, 63))
                                                          : 6'($urandom_range(0, 7));
         bus.cmd_word_addr = 28'($urandom);
         bus.wr_en         = 1'($urandom_range(0, 1));
         bus.wr_data       = $urandom;
         bus.wr_mask       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         bus.rd_en         = ((c % 400) < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
         step();
      end

      // Drain: feed write data until all commands finish, then empty the read FIFO.
      bus.cmd_en = 1'b0;
      bus.rd_en  = 1'b1;
      n = 0;
      while (!(job_kind == 0 && cmdq.size() == 0) && n < 5000) begin
         bus.wr_en = 1'b1; bus.wr_data = $urandom; bus.wr_mask = 4'h0;
         step(); n++;
      end
      if (n >= 5000) check("drain_timeout", 32'd1, 32'd0);
      bus.wr_en = 1'b0;
      repeat (70) step();
      bus.rd_en = 1'b0;
      step();
      check("drain_rd_empty", 32'(bus.rd_empty), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
